alu_out_stage: RTL

ALU_OUT_STAGE -- requirements
Module: alu_out_stage

---
 rtl/alu_out_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_out_stage.sv
// ALU output stage: latches ALU/shifter results and runs a
// 32-iteration shift-add unsigned multiply into HI/LO.
module alu_out_stage #(
  parameter logic [5:0] ADD   = 6'b100000,
  parameter logic [5:0] SUB   = 6'b100010,
  parameter logic [5:0] AND   = 6'b100100,
  parameter logic [5:0] OR    = 6'b100101,
  parameter logic [5:0] SLT   = 6'b101010,
  parameter logic [5:0] SRL   = 6'b000010,
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] MFHI  = 6'b010000,
  parameter logic [5:0] MFLO  = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [5:0]  signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] aluOut,
  input  logic [31:0] shiftOut,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] dout_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic [63:0] prod_d;
  logic [4:0]  cnt_q;
  logic        done_q;
  logic [31:0] res_d;
  logic        is_alu;

  assign is_alu = (signal == ADD) ||
                  (signal == SUB) ||
                  (signal == AND) ||
                  (signal == OR)  ||
                  (signal == SLT);

  always_comb begin
    res_d = 32'h0;
    unique case (1'b1)
      is_alu:           res_d = aluOut;
      (signal == SRL):  res_d = shiftOut;
      (signal == MFHI): res_d = hi_q;
      (signal == MFLO): res_d = lo_q;
      default:          res_d = 32'h0;
    endcase
  end

  assign prod_d = mplier_q[0] ? (prod_q + mcand_q)
                              : prod_q;

  // cnt_q wraps to 0 on the 32nd iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      dout_q   <= 32'h0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      mcand_q  <= 64'h0;
      mplier_q <= 32'h0;
      prod_q   <= 64'h0;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (valid) begin
            if (signal == MULTU) begin
              mcand_q  <= {32'h0, dataA};
              mplier_q <= dataB;
              prod_q   <= 64'h0;
              cnt_q    <= 5'd0;
              state_q  <= MUL;
            end else begin
              dout_q <= res_d;
            end
          end
        end
        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= prod_d[63:32];
            lo_q    <= prod_d[31:0];
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut = dout_q;
  assign busy    = (state_q == MUL);
  assign done    = done_q;

endmodule
